// File: rtl/monitor_pkg.sv
// Shared types and constants for the riscv-tests run monitor.
package monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_COLLECT = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      STAT_IDLE    = 2'b00,
      STAT_PASS    = 2'b01,
      STAT_FAIL    = 2'b10,
      STAT_TIMEOUT = 2'b11
   } status_e;

   // "OK\n\0", first result register in the most significant byte
   localparam logic [31:0] DEFAULT_PASS_SIG = 32'h4F4B_0A00;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/trace_ring.sv
// Ring buffer of the most recently retired {pc, insn} pairs, read relative to the newest entry.
module trace_ring #(
   parameter int XLEN        = 32,
   parameter int TRACE_DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear_i,
   input  logic                           push_i,
   input  logic [XLEN-1:0]                push_pc_i,
   input  logic [31:0]                    push_insn_i,
   input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx_i,
   output logic [XLEN-1:0]                rd_pc_o,
   output logic [31:0]                    rd_insn_o,
   output logic [$clog2(TRACE_DEPTH):0]   fill_o
);

   localparam int IW = $clog2(TRACE_DEPTH);

   logic [XLEN-1:0] pc_q   [TRACE_DEPTH];
   logic [31:0]     insn_q [TRACE_DEPTH];
   logic [IW-1:0]   wptr_q;
   logic [IW:0]     fill_q;
   logic [IW-1:0]   rd_slot_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         fill_q <= '0;
         for (int i = 0; i < TRACE_DEPTH; i++) begin
            pc_q[i]   <= '0;
            insn_q[i] <= '0;
         end
      end else if (clear_i) begin
         wptr_q <= '0;
         fill_q <= '0;
      end else if (push_i) begin
         pc_q[wptr_q]   <= push_pc_i;
         insn_q[wptr_q] <= push_insn_i;
         wptr_q         <= wptr_q + IW'(1);
         if (fill_q != (IW+1)'(TRACE_DEPTH)) begin
            fill_q <= fill_q + (IW+1)'(1);
         end
      end
   end

   // Stale slots beyond the fill count read as zero rather than old data.
   always_comb begin
      rd_slot_s = wptr_q - rd_idx_i - IW'(1);
      if ({1'b0, rd_idx_i} < fill_q) begin
         rd_pc_o   = pc_q[rd_slot_s];
         rd_insn_o = insn_q[rd_slot_s];
      end else begin
         rd_pc_o   = '0;
         rd_insn_o = 32'd0;
      end
   end

   assign fill_o = fill_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// Run monitor: arms on start, watches retirement/trap, enforces a watchdog,
// reads result registers after trap and reports pass/fail/timeout.
module riscv_test_monitor
   import monitor_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int TRACE_DEPTH    = 16,
   parameter int RESULT_REGS    = 4,
   parameter int RESULT_BASE    = 10,
   parameter logic [8*RESULT_REGS-1:0] PASS_SIG = (8*RESULT_REGS)'(DEFAULT_PASS_SIG)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           start,
   input  logic                           retire,
   input  logic [XLEN-1:0]                retire_pc,
   input  logic [31:0]                    retire_insn,
   input  logic                           trap,
   output logic [4:0]                     reg_rd_addr,
   input  logic [XLEN-1:0]                reg_rd_data,
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
   output logic [XLEN-1:0]                trace_rd_pc,
   output logic [31:0]                    trace_rd_insn,
   output logic [31:0]                    retired_count,
   output logic [8*RESULT_REGS-1:0]       result_bytes,
   output logic                           done,
   output logic [1:0]                     status
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam int KW = $clog2(RESULT_REGS + 1);
   localparam int RW = 8 * RESULT_REGS;
   localparam int IW = $clog2(TRACE_DEPTH);

   state_e          state_q, state_d;
   status_e         status_q, status_d;
   logic [CW-1:0]   cycle_q, cycle_d;
   logic [KW-1:0]   k_q, k_d;
   logic [31:0]     retired_q, retired_d;
   logic [RW-1:0]   result_q, result_d;
   logic [4:0]      addr_q, addr_d;
   logic            done_q, done_d;
   logic            arm_s, timeout_s, last_cap_s, push_s;
   logic [IW:0]     fill_s;
   logic            unused_s;

   assign arm_s      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign timeout_s  = (cycle_q == CW'(TIMEOUT_CYCLES - 1));
   assign last_cap_s = (k_q == KW'(RESULT_REGS));
   assign push_s     = (state_q == ST_RUN) && retire;
   assign unused_s   = ^{reg_rd_data[XLEN-1:8], fill_s};

   trace_ring #(
      .XLEN        (XLEN),
      .TRACE_DEPTH (TRACE_DEPTH)
   ) u_trace_ring (
      .clk         (clk),
      .rst_n       (resetn),
      .clear_i     (arm_s),
      .push_i      (push_s),
      .push_pc_i   (retire_pc),
      .push_insn_i (retire_insn),
      .rd_idx_i    (trace_rd_idx),
      .rd_pc_o     (trace_rd_pc),
      .rd_insn_o   (trace_rd_insn),
      .fill_o      (fill_s)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Trap wins over a watchdog expiry landing in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_RUN; else state_d = ST_IDLE;
         ST_RUN:     if (trap) state_d = ST_COLLECT;
                     else if (timeout_s) state_d = ST_DONE;
                     else state_d = ST_RUN;
         ST_COLLECT: if (last_cap_s) state_d = ST_DONE; else state_d = ST_COLLECT;
         ST_DONE:    if (start) state_d = ST_RUN; else state_d = ST_DONE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // k_q counts COLLECT cycles: address k is issued while k_q==k, its data lands while k_q==k+1.
   always_comb begin
      cycle_d   = cycle_q;
      k_d       = k_q;
      retired_d = retired_q;
      result_d  = result_q;
      addr_d    = 5'd0;
      done_d    = done_q;
      status_d  = status_q;
      if (arm_s) begin
         cycle_d   = '0;
         k_d       = '0;
         retired_d = 32'd0;
         result_d  = '0;
         done_d    = 1'b0;
         status_d  = STAT_IDLE;
      end else begin
         case (state_q)
            ST_RUN: begin
               cycle_d = cycle_q + CW'(1);
               if (retire) retired_d = sat_inc32(retired_q); else retired_d = retired_q;
               if (trap) begin
                  addr_d = 5'(RESULT_BASE);
                  k_d    = '0;
               end else if (timeout_s) begin
                  done_d   = 1'b1;
                  status_d = STAT_TIMEOUT;
               end else begin
                  addr_d = 5'd0;
               end
            end
            ST_COLLECT: begin
               k_d = k_q + KW'(1);
               if (k_q != '0) begin
                  result_d[8*(RESULT_REGS - int'(k_q)) +: 8] = reg_rd_data[7:0];
               end else begin
                  result_d = result_q;
               end
               if ((int'(k_q) + 1) < RESULT_REGS) begin
                  addr_d = 5'(RESULT_BASE + int'(k_q) + 1);
               end else begin
                  addr_d = 5'd0;
               end
               if (last_cap_s) begin
                  done_d   = 1'b1;
                  status_d = (result_d == PASS_SIG) ? STAT_PASS : STAT_FAIL;
               end else begin
                  done_d   = done_q;
               end
            end
            default: begin
               addr_d = 5'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cycle_q   <= '0;
         k_q       <= '0;
         retired_q <= 32'd0;
         result_q  <= '0;
         addr_q    <= 5'd0;
         done_q    <= 1'b0;
         status_q  <= STAT_IDLE;
      end else begin
         cycle_q   <= cycle_d;
         k_q       <= k_d;
         retired_q <= retired_d;
         result_q  <= result_d;
         addr_q    <= addr_d;
         done_q    <= done_d;
         status_q  <= status_d;
      end
   end

   assign reg_rd_addr   = addr_q;
   assign retired_count = retired_q;
   assign result_bytes  = result_q;
   assign done          = done_q;
   assign status        = status_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor (TIMEOUT_CYCLES=20, TRACE_DEPTH=4).
module tb_riscv_test_monitor;

   localparam int TO = 20;
   localparam int TD = 4;
   localparam int RR = 4;
   localparam int RB = 10;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        retire = 1'b0;
   logic [31:0] retire_pc = 32'd0;
   logic [31:0] retire_insn = 32'd0;
   logic        trap = 1'b0;
   logic [4:0]  reg_rd_addr;
   logic [31:0] reg_rd_data;
   logic [1:0]  trace_rd_idx = 2'd0;
   logic [31:0] trace_rd_pc;
   logic [31:0] trace_rd_insn;
   logic [31:0] retired_count;
   logic [31:0] result_bytes;
   logic        done;
   logic [1:0]  status;

   logic [31:0] regs [0:31];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   typedef struct { logic [31:0] res; logic [1:0] st; logic [31:0] cnt; int at; } done_exp_t;
   typedef struct { logic [4:0] a; int at; } addr_exp_t;
   done_exp_t done_q[$];
   addr_exp_t addr_q[$];

   riscv_test_monitor #(
      .XLEN(32), .TIMEOUT_CYCLES(TO), .TRACE_DEPTH(TD), .RESULT_REGS(RR), .RESULT_BASE(RB),
      .PASS_SIG(32'h4F4B_0A00)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .retire(retire), .retire_pc(retire_pc),
      .retire_insn(retire_insn), .trap(trap), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
      .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc), .trace_rd_insn(trace_rd_insn),
      .retired_count(retired_count), .result_bytes(result_bytes), .done(done), .status(status)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // register file with one-cycle read latency
   always @(posedge clk) reg_rd_data <= regs[reg_rd_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_regs(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      regs[RB]   = {24'hA55AC3, b0};
      regs[RB+1] = {24'h5AA53C, b1};
      regs[RB+2] = {24'hFFFFFF, b2};
      regs[RB+3] = {24'h123456, b3};
   endtask

   task automatic retire_one(input logic [31:0] pc, input logic [31:0] insn);
      retire = 1'b1; retire_pc = pc; retire_insn = insn;
      tick();
      retire = 1'b0;
   endtask

   // called at the negedge where trap is driven high
   task automatic expect_collect(input logic [31:0] res, input logic [1:0] st, input logic [31:0] cnt);
      int d;
      d = cyc;
      for (int k = 0; k < RR; k++) addr_q.push_back('{a: 5'(RB + k), at: d + 1 + k});
      done_q.push_back('{res: res, st: st, cnt: cnt, at: d + RR + 2});
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk(name, {63'd0, seen}, 64'd1);
   endtask

   task automatic chk_trace(input string name, input logic [1:0] idx, input logic [31:0] pc, input logic [31:0] insn);
      trace_rd_idx = idx;
      #1;
      chk({name, "_pc"}, trace_rd_pc, pc);
      chk({name, "_insn"}, trace_rd_insn, insn);
   endtask

   task automatic monitor_loop();
      logic      done_prev;
      addr_exp_t ae;
      done_exp_t de;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (reg_rd_addr != 5'd0) begin
               if (addr_q.size() == 0) begin
                  chk("addr_unexpected", reg_rd_addr, 64'd0);
               end else begin
                  ae = addr_q.pop_front();
                  chk("rd_addr", reg_rd_addr, ae.a);
                  chk("rd_addr_cycle", cyc, ae.at);
               end
            end
            if (done && !done_prev) begin
               if (done_q.size() == 0) begin
                  chk("done_unexpected", done, 64'd0);
               end else begin
                  de = done_q.pop_front();
                  chk("done_cycle", cyc, de.at);
                  chk("status", status, de.st);
                  chk("result_bytes", result_bytes, de.res);
                  chk("retired_count", retired_count, de.cnt);
               end
            end
         end
         done_prev = done;
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      fork
         monitor_loop();
      join_none
      repeat (3) tick();
      chk("rst_done", done, 0);
      chk("rst_status", status, 0);
      chk("rst_addr", reg_rd_addr, 0);
      chk("rst_retired", retired_count, 0);
      chk("rst_result", result_bytes, 0);
      chk_trace("rst_trace", 2'd0, 32'd0, 32'd0);
      resetn = 1'b1;
      tick();

      // pass run, start in RUN ignored, retire coincident with trap recorded
      set_regs(8'h4F, 8'h4B, 8'h0A, 8'h00);
      start = 1'b1; tick(); start = 1'b0;
      retire_one(32'h0, 32'h0000_0013);
      start = 1'b1; tick(); start = 1'b0;
      retire_one(32'h4, 32'h0010_0093);
      retire = 1'b1; retire_pc = 32'h8; retire_insn = 32'h0000_0073; trap = 1'b1;
      expect_collect(32'h4F4B_0A00, 2'b01, 32'd3);
      tick();
      retire = 1'b0; trap = 1'b0;
      wait_done("pass_done_bound");
      retire_one(32'h44, 32'h4444_4444);
      tick();
      chk("done_hold_retired", retired_count, 3);
      chk("done_hold_status", status, 2'b01);
      chk_trace("a_idx0", 2'd0, 32'h8, 32'h0000_0073);
      chk_trace("a_idx1", 2'd1, 32'h4, 32'h0010_0093);
      chk_trace("a_idx2", 2'd2, 32'h0, 32'h0000_0013);
      chk_trace("a_idx3", 2'd3, 32'h0, 32'h0);

      // re-arm from DONE, fail run, ring wrap
      set_regs(8'h45, 8'h72, 8'h72, 8'h0A);
      start = 1'b1; tick(); start = 1'b0;
      chk("rearm_done", done, 0);
      chk("rearm_status", status, 0);
      chk("rearm_retired", retired_count, 0);
      chk_trace("rearm_idx0", 2'd0, 32'h0, 32'h0);
      for (int i = 0; i < 6; i++) retire_one(32'h10 + 32'(4 * i), 32'h1000 + 32'(i));
      trap = 1'b1;
      expect_collect(32'h4572_720A, 2'b10, 32'd6);
      tick();
      trap = 1'b0;
      wait_done("fail_done_bound");
      chk_trace("b_idx0", 2'd0, 32'h24, 32'h1005);
      chk_trace("b_idx1", 2'd1, 32'h20, 32'h1004);
      chk_trace("b_idx3", 2'd3, 32'h18, 32'h1002);

      // watchdog expiry, no reads issued
      done_q.push_back('{res: 32'h0, st: 2'b11, cnt: 32'd2, at: cyc + TO + 1});
      start = 1'b1; tick(); start = 1'b0;
      retire_one(32'h100, 32'hAAAA_0001);
      retire_one(32'h104, 32'hAAAA_0002);
      wait_done("timeout_done_bound");
      chk_trace("c_idx0", 2'd0, 32'h104, 32'hAAAA_0002);
      chk_trace("c_idx1", 2'd1, 32'h100, 32'hAAAA_0001);
      chk_trace("c_idx2", 2'd2, 32'h0, 32'h0);
      chk_trace("c_idx3", 2'd3, 32'h0, 32'h0);

      // trap in the final watchdog cycle takes the COLLECT path
      set_regs(8'h4F, 8'h4B, 8'h0A, 8'h00);
      start = 1'b1; tick(); start = 1'b0;
      repeat (TO - 1) tick();
      trap = 1'b1;
      expect_collect(32'h4F4B_0A00, 2'b01, 32'd0);
      tick();
      trap = 1'b0;
      wait_done("edge_trap_done_bound");

      // reset during COLLECT aborts with no report
      start = 1'b1; tick(); start = 1'b0;
      retire_one(32'h200, 32'hBBBB_0001);
      trap = 1'b1;
      for (int k = 0; k < 3; k++) addr_q.push_back('{a: 5'(RB + k), at: cyc + 1 + k});
      tick();
      trap = 1'b0;
      tick();
      tick();
      chk("partial_result", result_bytes, 32'h4F00_0000);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_done", done, 0);
      chk("mid_rst_status", status, 0);
      chk("mid_rst_addr", reg_rd_addr, 0);
      chk("mid_rst_retired", retired_count, 0);
      chk("mid_rst_result", result_bytes, 0);
      chk_trace("mid_rst_trace", 2'd0, 32'h0, 32'h0);
      tick();
      resetn = 1'b1;
      repeat (8) tick();
      chk("post_rst_done", done, 0);
      chk("addr_queue_empty", addr_q.size(), 0);
      chk("done_queue_empty", done_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
